// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler
// Sequences a shared two-digit hex seven-segment driver. On a load strobe it
// snapshots the operands and product into shadow registers and bumps a load
// counter. It rotates the display through the enabled pages (operands,
// product, load count) at a dwell rate derived from the digit-scan timebase.
module seg_display_scheduler #(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned DWELL_SCANS = 500,
  parameter logic [2:0]  PAGE_MASK   = 3'b111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [7:0] prod,
  input  logic       load,
  input  logic       hold,
  output logic [3:0] val1,
  output logic [3:0] val2,
  output logic [1:0] page,
  output logic       blank,
  output logic       scan_tick,
  output logic       digit_sel
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = $clog2(DWELL_SCANS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_SCANS - 1);

  localparam logic [1:0] PG_OPER  = 2'd0;
  localparam logic [1:0] PG_PROD  = 2'd1;
  localparam logic [1:0] PG_COUNT = 2'd2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_presc;
  logic          r_scan_tick;
  logic          r_digit_sel;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_page;
  logic [3:0]    r_shadow_a;
  logic [3:0]    r_shadow_b;
  logic [7:0]    r_shadow_p;
  logic [7:0]    r_load_cnt;
  logic          w_blank;
  logic [3:0]    w_val1;
  logic [3:0]    w_val2;

  // Lowest enabled page; falls back to OPER when no page is enabled.
  function automatic logic [1:0] first_page(input logic [2:0] mask);
    logic [1:0] res;
    if (mask[0]) begin
      res = PG_OPER;
    end else if (mask[1]) begin
      res = PG_PROD;
    end else if (mask[2]) begin
      res = PG_COUNT;
    end else begin
      res = PG_OPER;
    end
    return res;
  endfunction

  // Next enabled page in ascending order, wrapping COUNT back to OPER.
  function automatic logic [1:0] next_page(input logic [1:0] cur, input logic [2:0] mask);
    logic [1:0] res;
    case (cur)
      PG_OPER: begin
        if (mask[1])      res = PG_PROD;
        else if (mask[2]) res = PG_COUNT;
        else              res = PG_OPER;
      end
      PG_PROD: begin
        if (mask[2])      res = PG_COUNT;
        else if (mask[0]) res = PG_OPER;
        else              res = PG_PROD;
      end
      PG_COUNT: begin
        if (mask[0])      res = PG_OPER;
        else if (mask[1]) res = PG_PROD;
        else              res = PG_COUNT;
      end
      default: res = first_page(mask);
    endcase
    return res;
  endfunction

  // Free-running scan prescaler, registered tick and digit toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc     <= '0;
      r_scan_tick <= 1'b0;
      r_digit_sel <= 1'b0;
    end else begin
      if (r_presc == PRESC_MAX) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      r_scan_tick <= (r_presc == PRESC_MAX);
      if (r_scan_tick) begin
        r_digit_sel <= ~r_digit_sel;
      end else begin
        r_digit_sel <= r_digit_sel;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: leave IDLE on the first load, but only if a page exists to show.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (load && (PAGE_MASK != 3'b000)) begin
          w_state_next = SHOW;
        end else begin
          w_state_next = IDLE;
        end
      end
      SHOW:    w_state_next = SHOW;
      default: w_state_next = IDLE;
    endcase
  end

  // Snapshot capture and load counter; inputs are only sampled on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow_a <= 4'd0;
      r_shadow_b <= 4'd0;
      r_shadow_p <= 8'd0;
      r_load_cnt <= 8'd0;
    end else if (load) begin
      r_shadow_a <= a;
      r_shadow_b <= b;
      r_shadow_p <= prod;
      r_load_cnt <= r_load_cnt + 8'd1;
    end else begin
      r_shadow_a <= r_shadow_a;
      r_shadow_b <= r_shadow_b;
      r_shadow_p <= r_shadow_p;
      r_load_cnt <= r_load_cnt;
    end
  end

  // Page rotation: load restarts at the first page, otherwise dwell on scan ticks unless held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_page  <= PG_OPER;
      r_dwell <= '0;
    end else if (load) begin
      r_page  <= first_page(PAGE_MASK);
      r_dwell <= '0;
    end else if ((r_state == SHOW) && r_scan_tick && !hold) begin
      if (r_dwell == DWELL_MAX) begin
        r_dwell <= '0;
        r_page  <= next_page(r_page, PAGE_MASK);
      end else begin
        r_dwell <= r_dwell + DW'(1);
        r_page  <= r_page;
      end
    end else begin
      r_page  <= r_page;
      r_dwell <= r_dwell;
    end
  end

  // Page content mux; everything dark until the first valid snapshot.
  always_comb begin
    w_blank = (r_state != SHOW);
    w_val1  = 4'd0;
    w_val2  = 4'd0;
    if (w_blank) begin
      w_val1 = 4'd0;
      w_val2 = 4'd0;
    end else begin
      case (r_page)
        PG_OPER: begin
          w_val1 = r_shadow_a;
          w_val2 = r_shadow_b;
        end
        PG_PROD: begin
          w_val1 = r_shadow_p[7:4];
          w_val2 = r_shadow_p[3:0];
        end
        PG_COUNT: begin
          w_val1 = r_load_cnt[7:4];
          w_val2 = r_load_cnt[3:0];
        end
        default: begin
          w_val1 = 4'd0;
          w_val2 = 4'd0;
        end
      endcase
    end
  end

  assign val1      = w_val1;
  assign val2      = w_val2;
  assign page      = w_blank ? PG_OPER : r_page;
  assign blank     = w_blank;
  assign scan_tick = r_scan_tick;
  assign digit_sel = r_digit_sel;

endmodule
